// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//
// Program counter and branch resolution for the processor fetch path.
// Branch targets come from a runtime-writable target table. The unit also
// has a return-address stack for call/ret and a halt/done handshake.
//
// Per-cycle priority, highest first:
//   reset > start > done (held) > stall > halt > ret > call > br_abs
//   > br_rel_z/br_rel_nz > PC+1
//
// Optional feature macro: BRANCH_STATS_EN
//   defined   : taken_cnt counts taken transfers and saturates at 16'hFFFF
//   undefined : taken_cnt is tied to zero and no counter logic is built
//
// Ports
//   CLK         rising-edge clock
//   reset       synchronous, active-low reset (also clears the target table)
//   start       restart: pc=0; clears done, stack pointer, err, taken_cnt
//   stall       hold pc, stack and done for this cycle
//   br_abs      pc <= tbl[lut_idx]
//   br_rel_z    if zero_flag,  pc <= pc + tbl[lut_idx]
//   br_rel_nz   if !zero_flag, pc <= pc + tbl[lut_idx]
//   zero_flag   registered ALU zero flag
//   call        push pc+1, pc <= tbl[lut_idx]
//   ret         pc <= popped return address
//   halt        stop the program; done rises on the next edge
//   lut_idx     target table read index
//   tbl_we      target table write enable
//   tbl_widx    target table write index
//   tbl_wdata   target table write data
//   pc          current instruction address
//   done        program halted
//   stack_full  stack pointer == STACK_DEPTH
//   stack_empty stack pointer == 0
//   err         sticky: call on a full stack or ret on an empty stack
//   taken_cnt   taken transfer count (see BRANCH_STATS_EN)
// -----------------------------------------------------------------------------
module branch_unit #(
  parameter  int PC_W        = 16,
  parameter  int LUT_ENTRIES = 16,
  parameter  int STACK_DEPTH = 4,
  localparam int IDX_W       = $clog2(LUT_ENTRIES)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             br_abs,
  input  logic             br_rel_z,
  input  logic             br_rel_nz,
  input  logic             zero_flag,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  input  logic [IDX_W-1:0] lut_idx,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_widx,
  input  logic [PC_W-1:0]  tbl_wdata,
  output logic [PC_W-1:0]  pc,
  output logic             done,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             err,
  output logic [15:0]      taken_cnt
);

  // The stack pointer has to reach STACK_DEPTH, so it is one state wider
  // than the stack index.
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int STK_IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0]   tbl_q   [LUT_ENTRIES];
  logic [PC_W-1:0]   stack_q [STACK_DEPTH];
  logic [PC_W-1:0]   pc_q;
  logic [SP_W-1:0]   sp_q;
  logic              done_q;
  logic              err_q;

  logic [PC_W-1:0]   pc_nxt;
  logic [SP_W-1:0]   sp_nxt;
  logic              done_nxt;
  logic              err_nxt;
  logic              push_en;
  logic              taken;

  logic [PC_W-1:0]   tbl_rdata;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_rel;
  logic signed [PC_W-1:0] rel_off_s;
  logic [STK_IW-1:0] push_idx;
  logic [STK_IW-1:0] pop_idx;
  logic              rel_taken;

  // Combinational table read. A same-cycle write to the same index lands at
  // the edge, so the read still sees the old entry.
  assign tbl_rdata = tbl_q[lut_idx];

  // Table entries are two's complement offsets for relative branches. The sum
  // wraps modulo 2^PC_W on purpose.
  assign rel_off_s = $signed(tbl_rdata);
  assign pc_rel    = $unsigned($signed(pc_q) + rel_off_s);
  assign pc_inc    = pc_q + PC_W'(1);

  assign push_idx  = STK_IW'(sp_q);
  assign pop_idx   = STK_IW'(sp_q - SP_W'(1));

  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  // br_rel_z and br_rel_nz share a priority level. If both are asserted, one
  // of the two conditions always holds.
  assign rel_taken = (br_rel_z && zero_flag) || (br_rel_nz && !zero_flag);

  always_comb begin
    pc_nxt   = pc_q;
    sp_nxt   = sp_q;
    done_nxt = done_q;
    err_nxt  = err_q;
    push_en  = 1'b0;
    taken    = 1'b0;
    if (start) begin
      pc_nxt   = '0;
      sp_nxt   = '0;
      done_nxt = 1'b0;
      err_nxt  = 1'b0;
    end else if (done_q || stall) begin
      // hold everything
    end else if (halt) begin
      done_nxt = 1'b1;
    end else if (ret) begin
      if (!stack_empty) begin
        pc_nxt = stack_q[pop_idx];
        sp_nxt = sp_q - SP_W'(1);
        taken  = 1'b1;
      end else begin
        err_nxt = 1'b1;
        pc_nxt  = pc_inc;
      end
    end else if (call) begin
      if (!stack_full) begin
        push_en = 1'b1;
        sp_nxt  = sp_q + SP_W'(1);
        pc_nxt  = tbl_rdata;
        taken   = 1'b1;
      end else begin
        err_nxt = 1'b1;
        pc_nxt  = pc_inc;
      end
    end else if (br_abs) begin
      pc_nxt = tbl_rdata;
      taken  = 1'b1;
    end else if (br_rel_z || br_rel_nz) begin
      if (rel_taken) begin
        pc_nxt = pc_rel;
        taken  = 1'b1;
      end else begin
        pc_nxt = pc_inc;
      end
    end else begin
      pc_nxt = pc_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      pc_q   <= '0;
      sp_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < LUT_ENTRIES; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_nxt;
      sp_q   <= sp_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      // Table writes are accepted even while stalled or halted.
      if (tbl_we) begin
        tbl_q[tbl_widx] <= tbl_wdata;
      end
    end
  end

  // Stack contents carry data only. Validity is tracked by sp_q, so the
  // stack needs no reset.
  always_ff @(posedge CLK) begin
    if (reset && push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc   = pc_q;
  assign done = done_q;
  assign err  = err_q;

`ifdef BRANCH_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (taken) begin
      cnt_q <= sat_inc16(cnt_q);
    end
  end

  assign taken_cnt = cnt_q;
`else
  logic unused_taken;
  assign unused_taken = taken;
  assign taken_cnt    = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

  logic        CLK;
  logic        reset;
  logic        start;
  logic        stall;
  logic        br_abs;
  logic        br_rel_z;
  logic        br_rel_nz;
  logic        zero_flag;
  logic        call;
  logic        ret;
  logic        halt;
  logic [3:0]  lut_idx;
  logic        tbl_we;
  logic [3:0]  tbl_widx;
  logic [15:0] tbl_wdata;
  logic [15:0] pc;
  logic        done;
  logic        stack_full;
  logic        stack_empty;
  logic        err;
  logic [15:0] taken_cnt;

  int n_total = 0;
  int n_bad   = 0;

  branch_unit #(.PC_W(16), .LUT_ENTRIES(16), .STACK_DEPTH(4)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .br_abs      (br_abs),
    .br_rel_z    (br_rel_z),
    .br_rel_nz   (br_rel_nz),
    .zero_flag   (zero_flag),
    .call        (call),
    .ret         (ret),
    .halt        (halt),
    .lut_idx     (lut_idx),
    .tbl_we      (tbl_we),
    .tbl_widx    (tbl_widx),
    .tbl_wdata   (tbl_wdata),
    .pc          (pc),
    .done        (done),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err         (err),
    .taken_cnt   (taken_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Control bit masks
  localparam logic [8:0] C_NONE  = 9'h000;
  localparam logic [8:0] C_START = 9'h001;
  localparam logic [8:0] C_STALL = 9'h002;
  localparam logic [8:0] C_ABS   = 9'h004;
  localparam logic [8:0] C_RZ    = 9'h008;
  localparam logic [8:0] C_RNZ   = 9'h010;
  localparam logic [8:0] C_ZF    = 9'h020;
  localparam logic [8:0] C_CALL  = 9'h040;
  localparam logic [8:0] C_RET   = 9'h080;
  localparam logic [8:0] C_HALT  = 9'h100;

  // Expected flag nibble: {done, stack_full, stack_empty, err}
  localparam logic [3:0] F_E   = 4'b0010;
  localparam logic [3:0] F_0   = 4'b0000;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic        rst_n;
    logic [8:0]  ctl;
    logic [3:0]  idx;
    logic        we;
    logic [3:0]  widx;
    logic [15:0] wdata;
    logic [15:0] epc;
    logic [3:0]  eflags;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [8:0] c, input logic [3:0] ix,
                              input logic w, input logic [3:0] wi, input logic [15:0] wd,
                              input logic [15:0] epc, input logic [3:0] ef);
    vec_t v;
    v.rst_n = r; v.ctl = c; v.idx = ix; v.we = w; v.widx = wi; v.wdata = wd;
    v.epc = epc; v.eflags = ef;
    return v;
  endfunction

  task automatic apply(input logic r, input logic [8:0] c, input logic [3:0] ix,
                       input logic w, input logic [3:0] wi, input logic [15:0] wd,
                       input logic [15:0] epc, input logic [3:0] ef, input string nm);
    reset     = r;
    start     = c[0];
    stall     = c[1];
    br_abs    = c[2];
    br_rel_z  = c[3];
    br_rel_nz = c[4];
    zero_flag = c[5];
    call      = c[6];
    ret       = c[7];
    halt      = c[8];
    lut_idx   = ix;
    tbl_we    = w;
    tbl_widx  = wi;
    tbl_wdata = wd;
    @(posedge CLK);
    #1;
    n_total++;
    if ({pc, done, stack_full, stack_empty, err} !== {epc, ef}) begin
      n_bad++;
      $display("FAIL %s: got pc=%h dfee=%b want pc=%h dfee=%b",
               nm, pc, {done, stack_full, stack_empty, err}, epc, ef);
    end
  endtask

  task automatic check_cnt(input logic [15:0] want_if_on, input string nm);
    logic [15:0] want;
    want = STATS ? want_if_on : 16'h0000;
    n_total++;
    if (taken_cnt !== want) begin
      n_bad++;
      $display("FAIL %s: got taken_cnt=%0d want %0d", nm, taken_cnt, want);
    end
  endtask

  vec_t vt [29];

  initial begin
    vt[0]  = mk(0, C_NONE,             0, 0, 0, 16'h0000, 16'h0000, F_E);
    vt[1]  = mk(0, C_NONE,             0, 0, 0, 16'h0000, 16'h0000, F_E);
    vt[2]  = mk(1, C_NONE,             0, 0, 0, 16'h0000, 16'h0001, F_E);
    vt[3]  = mk(1, C_NONE,             0, 0, 0, 16'h0000, 16'h0002, F_E);
    vt[4]  = mk(1, C_NONE,             0, 0, 0, 16'h0000, 16'h0003, F_E);
    vt[5]  = mk(1, C_NONE,             0, 1, 3, 16'hFFFE, 16'h0004, F_E);
    vt[6]  = mk(1, C_NONE,             0, 1, 4, 16'd10,   16'h0005, F_E);
    vt[7]  = mk(1, C_ABS,              4, 0, 0, 16'h0000, 16'd10,   F_E);
    vt[8]  = mk(1, C_RNZ,              3, 0, 0, 16'h0000, 16'd8,    F_E);
    vt[9]  = mk(1, C_ABS,              4, 0, 0, 16'h0000, 16'd10,   F_E);
    vt[10] = mk(1, C_RNZ | C_ZF,       3, 0, 0, 16'h0000, 16'd11,   F_E);
    vt[11] = mk(1, C_RZ | C_ZF,        3, 1, 1, 16'd40,   16'd9,    F_E);
    vt[12] = mk(1, C_NONE,             0, 1, 5, 16'd5,    16'd10,   F_E);
    vt[13] = mk(1, C_ABS,              5, 1, 6, 16'hFFFF, 16'd5,    F_E);
    vt[14] = mk(1, C_CALL,             1, 0, 0, 16'h0000, 16'd40,   F_0);
    vt[15] = mk(1, C_NONE,             0, 0, 0, 16'h0000, 16'd41,   F_0);
    vt[16] = mk(1, C_NONE,             0, 0, 0, 16'h0000, 16'd42,   F_0);
    vt[17] = mk(1, C_RET,              0, 0, 0, 16'h0000, 16'd6,    F_E);
    vt[18] = mk(1, C_ABS,              6, 0, 0, 16'h0000, 16'hFFFF, F_E);
    vt[19] = mk(1, C_NONE,             0, 0, 0, 16'h0000, 16'h0000, F_E);
    vt[20] = mk(1, C_ABS,              6, 1, 7, 16'h0003, 16'hFFFF, F_E);
    vt[21] = mk(1, C_RZ | C_ZF,        7, 0, 0, 16'h0000, 16'h0002, F_E);
    vt[22] = mk(1, C_ABS | C_RZ | C_ZF, 4, 0, 0, 16'h0000, 16'd10,  F_E);
    vt[23] = mk(1, C_START,            0, 0, 0, 16'h0000, 16'h0000, F_E);
    vt[24] = mk(1, C_ABS,              2, 1, 2, 16'd7,    16'h0000, F_E);
    vt[25] = mk(1, C_ABS,              2, 0, 0, 16'h0000, 16'd7,    F_E);
    vt[26] = mk(1, C_STALL | C_ABS,    4, 0, 0, 16'h0000, 16'd7,    F_E);
    vt[27] = mk(1, C_STALL,            0, 1, 8, 16'd100,  16'd7,    F_E);
    vt[28] = mk(1, C_ABS,              8, 0, 0, 16'h0000, 16'd100,  F_E);

    for (int i = 0; i < 29; i++) begin
      apply(vt[i].rst_n, vt[i].ctl, vt[i].idx, vt[i].we, vt[i].widx, vt[i].wdata,
            vt[i].epc, vt[i].eflags, $sformatf("vec%0d", i));
      if (i == 25) check_cnt(16'd2, "cnt_after_same_idx_write");
    end
    check_cnt(16'd3, "cnt_with_stall");

    // Nested calls past the stack depth, then unwind past empty
    apply(1, C_START, 0, 0, 0, 16'h0,  16'h0000, F_E, "nest_start");
    apply(1, C_STALL, 0, 1, 9,  16'h20, 16'h0000, F_E, "nest_wr9");
    apply(1, C_STALL, 0, 1, 10, 16'h30, 16'h0000, F_E, "nest_wr10");
    apply(1, C_STALL, 0, 1, 11, 16'h40, 16'h0000, F_E, "nest_wr11");
    apply(1, C_STALL, 0, 1, 12, 16'h50, 16'h0000, F_E, "nest_wr12");
    apply(1, C_STALL, 0, 1, 13, 16'd20, 16'h0000, F_E, "nest_wr13");
    apply(1, C_CALL,  9,  0, 0, 16'h0, 16'h0020, 4'b0000, "call1");
    apply(1, C_CALL,  10, 0, 0, 16'h0, 16'h0030, 4'b0000, "call2");
    apply(1, C_CALL,  11, 0, 0, 16'h0, 16'h0040, 4'b0000, "call3");
    apply(1, C_CALL,  12, 0, 0, 16'h0, 16'h0050, 4'b0100, "call4_full");
    apply(1, C_CALL,  9,  0, 0, 16'h0, 16'h0051, 4'b0101, "call5_overflow");
    apply(1, C_RET,   0,  0, 0, 16'h0, 16'h0041, 4'b0001, "ret1");
    apply(1, C_RET,   0,  0, 0, 16'h0, 16'h0031, 4'b0001, "ret2");
    apply(1, C_RET,   0,  0, 0, 16'h0, 16'h0021, 4'b0001, "ret3");
    apply(1, C_RET,   0,  0, 0, 16'h0, 16'h0001, 4'b0011, "ret4_empty");
    apply(1, C_RET,   0,  0, 0, 16'h0, 16'h0002, 4'b0011, "ret5_underflow");

    // Halt / done handshake, table writes while done, restart
    apply(1, C_START,         0,  0, 0,  16'h0,  16'h0000, F_E,     "halt_start");
    apply(1, C_ABS,           13, 0, 0,  16'h0,  16'd20,   F_E,     "goto20");
    apply(1, C_HALT,          0,  0, 0,  16'h0,  16'd20,   4'b1010, "halt");
    apply(1, C_ABS | C_CALL,  9,  0, 0,  16'h0,  16'd20,   4'b1010, "done_ignores_ctl");
    apply(1, C_ABS,           9,  1, 14, 16'h77, 16'd20,   4'b1010, "done_tbl_write");
    apply(1, C_START,         0,  0, 0,  16'h0,  16'h0000, F_E,     "restart");
    apply(1, C_ABS,           14, 0, 0,  16'h0,  16'h0077, F_E,     "read_done_write");

    // Reset in the middle of a call sequence also clears the table
    apply(1, C_CALL,          9,  0, 0,  16'h0,  16'h0020, F_0,     "call_pre_reset");
    apply(0, C_CALL,          9,  0, 0,  16'h0,  16'h0000, F_E,     "reset_mid_call");
    apply(1, C_NONE,          0,  0, 0,  16'h0,  16'h0001, F_E,     "post_reset");
    apply(1, C_ABS,           14, 0, 0,  16'h0,  16'h0000, F_E,     "tbl_cleared");
    check_cnt(16'd1, "cnt_after_reset");

    // Priority corners
    apply(1, C_CALL | C_RET,  9,  0, 0,  16'h0,  16'h0001, 4'b0011, "ret_over_call");
    apply(1, C_STALL | C_HALT, 0, 0, 0,  16'h0,  16'h0001, 4'b0011, "stall_over_halt");
    apply(1, C_HALT | C_RET,  0,  0, 0,  16'h0,  16'h0001, 4'b1011, "halt_over_ret");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
